// File: rtl/uart_rx_sequencer_if.sv
// uart_rx_sequencer_if: serial line, note handshake and status pulses of the
// sequencer UART receiver, grouped in one bundle.
// slave  = the receiver (samples sig, produces notes and pulses)
// master = the consumer (drives the line and ready, reads notes)
interface uart_rx_sequencer_if;
   logic       sig;
   logic [7:0] data;
   logic [3:0] button_index;
   logic [3:0] pitch;
   logic       valid;
   logic       ready;
   logic       sync_pulse;
   logic       frame_error;
   logic       overrun;

   modport master (
      output sig, ready,
      input  data, button_index, pitch, valid, sync_pulse, frame_error, overrun
   );

   modport slave (
      input  sig, ready,
      output data, button_index, pitch, valid, sync_pulse, frame_error, overrun
   );
endinterface

// File: rtl/uart_rx_sequencer.sv
// uart_rx_sequencer: 8N1 UART receiver that turns the serial step stream into
// note packets {pitch, button_index} on a valid/ready handshake, plus a
// one-cycle pulse for every SYNC_BYTE marker.
// Optional build macro UART_RX_MAJORITY_EN: every start/data/stop decision is a
// 2-of-3 vote over the samples at mid-1, mid and mid+1, taken one cycle later.
module uart_rx_sequencer #(
   parameter int         CLK_FREQ   = 12_000_000,
   parameter int         BAUD_RATE  = 9600,
   parameter int         DATA_WIDTH = 8,
   parameter logic [7:0] SYNC_BYTE  = 8'hFF
) (
   input logic               clk,
   input logic               rst,
   uart_rx_sequencer_if.slave bus
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam int HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
`ifdef UART_RX_MAJORITY_EN
   localparam logic [CNT_W-1:0] START_LAST = CNT_W'(HALF_BIT);
`else
   localparam logic [CNT_W-1:0] START_LAST = CNT_W'(HALF_BIT - 1);
`endif
   localparam logic [2:0]       DATA_LAST  = 3'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } state_t;

   state_t           r_state;
   state_t           w_nextState;
   logic             r_sync1;
   logic             r_sync2;
   logic [CNT_W-1:0] r_baudCnt;
   logic [2:0]       r_bitCnt;
   logic [7:0]       r_shift;
   logic [7:0]       r_data;
   logic             r_valid;
   logic             r_syncPulse;
   logic             r_frameError;
   logic             r_overrun;

   logic             w_s;
   logic [CNT_W-1:0] w_lastCount;
   logic             w_tick;
   logic             w_bit;
   logic             w_shiftEn;
   logic             w_accept;
   logic             w_frameErr;

   assign w_s         = r_sync2;
   assign w_lastCount = (r_state == START) ? START_LAST : BIT_LAST;
   assign w_tick      = (r_baudCnt == w_lastCount);

`ifdef UART_RX_MAJORITY_EN
   logic [1:0] r_vote;

   assign w_bit = (r_vote[0] & r_vote[1]) | (r_vote[0] & w_s) | (r_vote[1] & w_s);

   // Capture the two samples leading up to the decision count for the vote
   always_ff @(posedge clk) begin
      if (rst) begin
         r_vote <= 2'b11;
      end else begin
         if (r_baudCnt == w_lastCount - CNT_W'(2)) r_vote[0] <= w_s;
         if (r_baudCnt == w_lastCount - CNT_W'(1)) r_vote[1] <= w_s;
      end
   end
`else
   assign w_bit = w_s;
`endif

   // Two-flop synchronizer on the asynchronous line, idling high
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= bus.sig;
         r_sync2 <= r_sync1;
      end
   end

   // Frame state register
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_nextState;
   end

   // Next-state decode and per-cycle strobes for the datapath
   always_comb begin
      w_nextState = r_state;
      w_shiftEn   = 1'b0;
      w_accept    = 1'b0;
      w_frameErr  = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_s) w_nextState = START;
         end
         START: begin
            if (w_tick) w_nextState = w_bit ? IDLE : DATA;
         end
         DATA: begin
            if (w_tick) begin
               w_shiftEn = 1'b1;
               if (r_bitCnt == DATA_LAST) w_nextState = STOP;
            end
         end
         STOP: begin
            if (w_tick) begin
               if (w_bit) begin
                  w_accept    = 1'b1;
                  w_nextState = IDLE;
               end else begin
                  w_frameErr  = 1'b1;
                  w_nextState = BREAK;
               end
            end
         end
         BREAK: begin
            if (w_s) w_nextState = IDLE;
         end
         default: w_nextState = IDLE;
      endcase
   end

   // Baud counter runs only inside a frame and wraps to 0 at every decision
   always_ff @(posedge clk) begin
      if (rst) begin
         r_baudCnt <= '0;
      end else if ((r_state == START || r_state == DATA || r_state == STOP) && !w_tick) begin
         r_baudCnt <= r_baudCnt + CNT_W'(1);
      end else begin
         r_baudCnt <= '0;
      end
   end

   // Bit index and LSB-first shift register for the data bits
   always_ff @(posedge clk) begin
      if (rst) begin
         r_bitCnt <= 3'd0;
         r_shift  <= 8'h00;
      end else begin
         if (r_state != DATA) r_bitCnt <= 3'd0;
         else if (w_shiftEn)  r_bitCnt <= r_bitCnt + 3'd1;
         if (w_shiftEn) r_shift <= {w_bit, r_shift[7:1]};
      end
   end

   // Byte classification, note handshake and one-cycle status pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         r_data       <= 8'h00;
         r_valid      <= 1'b0;
         r_syncPulse  <= 1'b0;
         r_frameError <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         r_syncPulse  <= 1'b0;
         r_overrun    <= 1'b0;
         r_frameError <= w_frameErr;
         if (r_valid && bus.ready) r_valid <= 1'b0;
         if (w_accept) begin
            if (r_shift == SYNC_BYTE) begin
               r_syncPulse <= 1'b1;
            end else if (!r_valid || bus.ready) begin
               r_data  <= r_shift;
               r_valid <= 1'b1;
            end else begin
               r_overrun <= 1'b1;
            end
         end
      end
   end

   assign bus.data         = r_data;
   assign bus.button_index = r_data[3:0];
   assign bus.pitch        = r_data[7:4];
   assign bus.valid        = r_valid;
   assign bus.sync_pulse   = r_syncPulse;
   assign bus.frame_error  = r_frameError;
   assign bus.overrun      = r_overrun;

endmodule

// File: tb/tb_uart_rx_sequencer.sv
// tb_uart_rx_sequencer: directed bench for uart_rx_sequencer, run at 16 clocks
// per bit so the full scenario list stays short. Honours UART_RX_MAJORITY_EN
// for the mid-sample glitch expectation and the extra cycle of latency.
module tb_uart_rx_sequencer;

   localparam int CPB  = 16;
   localparam int HALF = CPB / 2;
`ifdef UART_RX_MAJORITY_EN
   localparam int         MAJ_DELAY  = 1;
   localparam logic [7:0] GLITCH_EXP = 8'h00;
`else
   localparam int         MAJ_DELAY  = 0;
   localparam logic [7:0] GLITCH_EXP = 8'h04;
`endif
   // Line drop (negedge) -> valid visible: 1 edge to reach the synchronizer,
   // 2 synchronizer edges, HALF edges to the start decision, 9 bit periods to
   // the stop decision, and the decision edge itself.
   localparam int EXP_LAT = 3 + HALF + 9 * CPB + MAJ_DELAY;

   logic clk;
   logic rst;
   uart_rx_sequencer_if bus ();

   uart_rx_sequencer #(
      .CLK_FREQ  (CPB * 9600),
      .BAUD_RATE (9600),
      .DATA_WIDTH(8),
      .SYNC_BYTE (8'hFF)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int tStart = 0;
   int riseCyc = 0;
   int validRise = 0;
   int validHigh = 0;
   int syncCnt = 0;
   int ferrCnt = 0;
   int ovrCnt = 0;
   logic prevValid = 1'b0;

   int snapRise, snapHigh, snapSync, snapFerr, snapOvr;

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Cycle counter on the active edge
   always @(posedge clk) cyc <= cyc + 1;

   // Event counters sampled on the inactive edge
   always @(negedge clk) begin
      if (bus.sync_pulse)  syncCnt++;
      if (bus.frame_error) ferrCnt++;
      if (bus.overrun)     ovrCnt++;
      if (bus.valid)       validHigh++;
      if (bus.valid && !prevValid) begin
         validRise++;
         riseCyc = cyc;
      end
      prevValid = bus.valid;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Sends one frame starting on a negedge; a high stop bit is followed by
   // one idle bit, a low stop bit leaves the line low for the caller
   task automatic applyStimulus(input logic [7:0] b, input logic stopBit);
      bus.sig = 1'b0;
      tStart  = cyc;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         bus.sig = b[i];
         repeat (CPB) @(negedge clk);
      end
      bus.sig = stopBit;
      repeat (CPB) @(negedge clk);
      if (stopBit) repeat (CPB) @(negedge clk);
   endtask

   task automatic snapshot();
      snapRise = validRise;
      snapHigh = validHigh;
      snapSync = syncCnt;
      snapFerr = ferrCnt;
      snapOvr  = ovrCnt;
   endtask

   initial begin
      logic [7:0] partial;
      bus.sig   = 1'b1;
      bus.ready = 1'b1;
      rst       = 1'b1;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      $display("[TB] reset state");
      checkOutput("rst_valid", 32'(bus.valid), 32'd0);
      checkOutput("rst_data", 32'(bus.data), 32'h00);
      checkOutput("rst_sync", 32'(bus.sync_pulse), 32'd0);
      checkOutput("rst_ferr", 32'(bus.frame_error), 32'd0);
      checkOutput("rst_ovr", 32'(bus.overrun), 32'd0);

      $display("[TB] note 0x35 with ready high");
      snapshot();
      applyStimulus(8'h35, 1'b1);
      checkOutput("n35_rise", 32'(validRise - snapRise), 32'd1);
      checkOutput("n35_high_cycles", 32'(validHigh - snapHigh), 32'd1);
      checkOutput("n35_data", 32'(bus.data), 32'h35);
      checkOutput("n35_pitch", 32'(bus.pitch), 32'h3);
      checkOutput("n35_button", 32'(bus.button_index), 32'h5);
      checkOutput("n35_latency", 32'(riseCyc - tStart), 32'(EXP_LAT));

      $display("[TB] sync marker 0xFF");
      snapshot();
      applyStimulus(8'hFF, 1'b1);
      checkOutput("sync_cycles", 32'(syncCnt - snapSync), 32'd1);
      checkOutput("sync_no_valid", 32'(validRise - snapRise), 32'd0);
      checkOutput("sync_data_kept", 32'(bus.data), 32'h35);

      $display("[TB] overrun with ready low");
      bus.ready = 1'b0;
      snapshot();
      applyStimulus(8'h12, 1'b1);
      applyStimulus(8'h34, 1'b1);
      checkOutput("ovr_valid", 32'(bus.valid), 32'd1);
      checkOutput("ovr_data", 32'(bus.data), 32'h12);
      checkOutput("ovr_pulses", 32'(ovrCnt - snapOvr), 32'd1);
      bus.ready = 1'b1;
      @(negedge clk);
      checkOutput("ovr_valid_drop", 32'(bus.valid), 32'd0);
      checkOutput("ovr_data_held", 32'(bus.data), 32'h12);

      $display("[TB] framing error and held-low line");
      snapshot();
      applyStimulus(8'hA7, 1'b0);
      repeat (20 * CPB) @(negedge clk);
      checkOutput("brk_no_valid", 32'(validRise - snapRise), 32'd0);
      bus.sig = 1'b1;
      repeat (2 * CPB) @(negedge clk);
      applyStimulus(8'h01, 1'b1);
      checkOutput("brk_ferr_pulses", 32'(ferrCnt - snapFerr), 32'd1);
      checkOutput("brk_rise_after", 32'(validRise - snapRise), 32'd1);
      checkOutput("brk_data", 32'(bus.data), 32'h01);

      $display("[TB] short low glitch on idle line");
      snapshot();
      bus.sig = 1'b0;
      repeat (5) @(negedge clk);
      bus.sig = 1'b1;
      repeat (3 * CPB) @(negedge clk);
      checkOutput("gl_valid", 32'(validRise - snapRise), 32'd0);
      checkOutput("gl_sync", 32'(syncCnt - snapSync), 32'd0);
      checkOutput("gl_ferr", 32'(ferrCnt - snapFerr), 32'd0);
      checkOutput("gl_ovr", 32'(ovrCnt - snapOvr), 32'd0);

      $display("[TB] reset in the middle of data bit 4");
      partial = 8'hC3;
      bus.sig = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         bus.sig = partial[i];
         repeat (CPB) @(negedge clk);
      end
      bus.sig = partial[4];
      repeat (HALF) @(negedge clk);
      rst = 1'b1;
      bus.sig = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("mid_rst_valid", 32'(bus.valid), 32'd0);
      checkOutput("mid_rst_data", 32'(bus.data), 32'h00);
      checkOutput("mid_rst_sync", 32'(bus.sync_pulse), 32'd0);
      checkOutput("mid_rst_ferr", 32'(bus.frame_error), 32'd0);
      checkOutput("mid_rst_ovr", 32'(bus.overrun), 32'd0);
      rst = 1'b0;
      repeat (2 * CPB) @(negedge clk);
      snapshot();
      applyStimulus(8'h5A, 1'b1);
      checkOutput("post_rst_data", 32'(bus.data), 32'h5A);
      checkOutput("post_rst_rise", 32'(validRise - snapRise), 32'd1);
      checkOutput("post_rst_ferr", 32'(ferrCnt - snapFerr), 32'd0);

      $display("[TB] one-cycle glitch at the bit 2 mid-sample of 0x00");
      snapshot();
      bus.sig = 1'b0;
      repeat (HALF + 3 * CPB) @(negedge clk);
      bus.sig = 1'b1;
      @(negedge clk);
      bus.sig = 1'b0;
      repeat (9 * CPB - (HALF + 3 * CPB) - 1) @(negedge clk);
      bus.sig = 1'b1;
      repeat (2 * CPB) @(negedge clk);
      checkOutput("mid_glitch_data", 32'(bus.data), 32'(GLITCH_EXP));
      checkOutput("mid_glitch_rise", 32'(validRise - snapRise), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_rx_sequencer.md
Name: uart_rx_sequencer

Overview:
- UART 8N1 receiver with sequencer packet decode; the receiving end of the board's serial step stream.
- Recovers bytes from the serial line and classifies each one. The sync marker (SYNC_BYTE) becomes a one-cycle pulse. Any other byte is a note packet {pitch[3:0], button_index[3:0]}.
- Note packets are presented on a valid/ready handshake so a model, host bridge or loopback checker can consume them.

Parameters:
- CLK_FREQ, 12_000_000, system clock in Hz.
- BAUD_RATE, 9600, line rate. CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (1250 at defaults).
- DATA_WIDTH, 8, data bits per frame. Must be 8 for packet decode.
- SYNC_BYTE, 8'hFF, marker byte for end of period.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- sig  in  1  asynchronous serial line; idles high.
- data  out  8  last accepted note byte.
- button_index  out  4  data[3:0].
- pitch  out  4  data[7:4].
- valid  out  1  note byte available.
- ready  in  1  consumer accepts; transfer occurs when valid&&ready.
- sync_pulse  out  1  one cycle high per received SYNC_BYTE.
- frame_error  out  1  one cycle high when the stop bit samples low.
- overrun  out  1  one cycle high when a note byte is dropped.

Behaviour:
- Reset: state=IDLE; valid, sync_pulse, frame_error and overrun all 0; data=0; synchronizer flops=1. Reset mid-frame aborts the frame silently with no pulses.
- Input path: sig passes through a 2-flop synchronizer (2-cycle latency). All decisions use the synchronized value s.
- IDLE: when s=0, go to START and clear the bit counter.
- START: at count CLKS_PER_BIT/2-1, sample s.
  - s=0: go to DATA and clear the counter.
  - s=1: false start (glitch), return to IDLE with no pulse.
- DATA: sample every CLKS_PER_BIT cycles, LSB first, into an 8-bit shift register. After the 8th bit, go to STOP.
- STOP: sample after CLKS_PER_BIT cycles.
  - s=1: byte accepted, go to IDLE.
  - s=0: frame_error pulse, byte discarded, go to BREAK.
- BREAK: stay until s=1, then go to IDLE. A held-low line must not retrigger frames.
- Latency: the stop sample is taken at edge N; sync_pulse, valid, frame_error and overrun are asserted from cycle N+1.
- Accepted byte == SYNC_BYTE: sync_pulse=1 for exactly 1 cycle. data and valid are untouched, and the byte never enters the handshake.
- Accepted note byte:
  - valid=0: load data and set valid=1.
  - valid=1 and ready=1 in the same cycle: the transfer completes and the new byte loads with valid staying 1; no overrun.
  - valid=1 and ready=0: the new byte is dropped, the old data is held, and overrun pulses for 1 cycle.
- Handshake: valid stays high and data stays stable until valid&&ready is seen; valid drops the next cycle. ready while valid=0 has no effect.
- Counters: the baud counter is wide enough for CLKS_PER_BIT-1 and wraps to 0 at each sample. The bit counter is 3 bits.
- Back-to-back frames are legal: a start edge is detected in IDLE on the cycle immediately after the stop-bit sample.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: each start, data and stop sample is the 2-of-3 majority of s at counts mid-1, mid and mid+1, where mid = CLKS_PER_BIT/2-1 for the start bit and the equivalent centre point for later bits. The decision and state advance occur at mid+1, so output latency grows by 1 cycle.
- Undefined: single sample at mid as described above; no extra latency.

Test Plan:
- Send 0x35 at 9600 baud with ready=1 -> valid high for 1 cycle with data=0x35, pitch=3, button_index=5. Assertion occurs 1 cycle after the stop sample, about 9.5 bit times (±2 clk) after the start edge.
- Send 0xFF -> sync_pulse high for exactly 1 cycle; valid stays 0; data unchanged.
- ready=0, send 0x12 then 0x34 -> valid=1 with data=0x12, one overrun pulse at the second stop bit. Raise ready -> valid drops the next cycle and data stays 0x12.
- Send frame 0xA7 with the stop bit forced low, then hold the line low for 20 bit times, then idle, then send 0x01 -> exactly one frame_error pulse, no valid during the low hold, then 0x01 received correctly.
- Low glitch of 300 clk on an idle line -> no state leaves IDLE beyond START, no pulses. Assert rst mid-frame at DATA bit 4 -> all outputs 0, and the next full frame 0x5A is received correctly.
- With UART_RX_MAJORITY_EN: single-cycle inverted glitch at the exact mid-sample of bit 2 of 0x00 -> data=0x00. Without the macro, the same glitch yields data=0x04.
